io_port: RTL and testbench
==========================

Name: io_port

Overview:
- I/O stage on the data bus of the 4-bit CPU.
- Output side: when the microcode asserts loadOut, the nibble on the bus is pushed into an output FIFO. The FIFO is drained by an external consumer through a valid/ready handshake.
- Input side: synchronizes external input pins and a strobe, latches a nibble on each strobe rising edge, and drives the latched nibble onto the tri-state bus when the microcode asserts oeIN.

Parameters:
- WIDTH, 4: bus/nibble width.
- DEPTH, 4: output FIFO entries; power of two, ≥2.
- SYNC_STAGES, 2: synchronizer flops on in_pins/in_strobe; ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- loadOut  in  1  microcode: push bus value into output FIFO.
- oeIN  in  1  microcode: drive in_latch onto bus.
- bus  inout  WIDTH  shared tri-state data bus.
- out_data  out  WIDTH  FIFO head nibble.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head this cycle.
- out_full  out  1  count == DEPTH.
- out_overflow  out  1  sticky: a push was dropped.
- in_pins  in  WIDTH  asynchronous external input nibble.
- in_strobe  in  1  asynchronous; rising edge means in_pins are stable.
- in_pending  out  1  latched input not yet read.

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr, rd_ptr and count go to 0.
  - out_valid=0, out_full=0, out_overflow=0.
  - in_latch=0 and in_pending=0.
  - Synchronizer chains and the strobe edge register go to 0.
  - bus goes to Z.
  - Reset mid-transfer discards FIFO contents and any pending input.
- Bus drive: bus = in_latch when oeIN=1, else all-Z. This is combinational; no other drive.
- Push: on a clk edge with loadOut=1, the bus value is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- Pop: on a clk edge with out_valid && out_ready, rd_ptr increments modulo DEPTH.
- FIFO is show-ahead: out_data = mem[rd_ptr] whenever out_valid=1. out_data is don't-care when empty.
- Latency: a push at edge N gives out_valid=1 after edge N.
- count is clog2(DEPTH)+1 bits:
  - push only: +1.
  - pop only: −1.
  - both: unchanged.
- Full boundary:
  - push and pop together while full: both happen; count stays DEPTH, and the write uses the freed slot.
  - push while full without pop: write dropped, pointers unchanged, out_overflow←1 and held until reset.
- Empty boundary: out_ready with out_valid=0 is ignored.
- Pointer wrap: DEPTH−1 → 0. The FIFO must stay correct across ≥2 full wraps.
- Input synchronizer:
  - in_pins and in_strobe each pass through SYNC_STAGES flops.
  - rise = strobe_sync & ~strobe_prev, where strobe_prev is registered each edge.
- Input capture:
  - on an edge with rise=1: in_latch←pins_sync, in_pending←1.
  - Latency: strobe high before edge 1 → in_pending=1 after edge SYNC_STAGES+1.
- Input read: on an edge with oeIN=1 and rise=0, in_pending←0.
- Simultaneous capture and read: capture wins. in_latch updates and in_pending stays 1. The bus carries the old in_latch during that cycle.
- Strobe held high: exactly one capture.
- Back-to-back strobes before a read: the latest value overwrites; no overflow flag on the input side.
- loadOut and oeIN together (IN→OUT loopback) is legal: the pushed value is in_latch.

Decomposition:
- Package io_port_pkg:
  - WIDTH_DEF=4, DEPTH_DEF=4, SYNC_DEF=2.
  - count_t typedef, logic [$clog2(DEPTH_DEF):0].
- Sub-module nibble_fifo holds memory, pointers, count, full/overflow and the valid/ready pop.
- io_port instantiates nibble_fifo and contains the synchronizer, edge detect, in_latch and bus driver.

Test Plan:
- Reset low at t=0 → out_valid=0, in_pending=0, bus=Z. Release reset, push 4'hA, 4'h3 (out_ready=0) → out_valid=1, out_data=4'hA. Raise out_ready → next cycle out_data=4'h3, then out_valid=0.
- Push 4'h1..4'h4 (full, out_full=1), then push 4'h5 with out_ready=0 → dropped, out_overflow=1 stays set. Drain reads 1,2,3,4.
- Full FIFO with loadOut and out_ready in the same cycle, bus=4'h9 → count stays 4, drain order 2,3,4,9.
- in_pins=4'h6, strobe pulse → in_pending=1 exactly 3 edges after strobe. oeIN=1 → bus=4'h6, in_pending=0 next edge. Strobe held high 10 cycles → one capture only.
- Strobe edge coincident with oeIN, old latch 4'h6, pins 4'hC → bus shows 4'h6, after edge in_latch=4'hC, in_pending=1.
- Push 3 nibbles, assert reset mid-drain → out_valid=0 and in_pending=0 immediately (asynchronous). Then 10 push/pop cycles with mixed out_ready wrap the pointers with data intact.

Source files
------------

// File: rtl/io_port_pkg.sv
// Shared defaults and types for the CPU I/O port.
package io_port_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int DEPTH_DEF = 4;
    localparam int SYNC_DEF  = 2;

    typedef logic [$clog2(DEPTH_DEF):0] count_t;

endpackage

// File: rtl/nibble_fifo.sv
// Show-ahead output FIFO with valid/ready drain and a sticky drop flag.
module nibble_fifo
    import io_port_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_full,
    output logic             out_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             pop;
    logic             push_ok;

    assign out_valid = (count != '0);
    assign out_full  = (count == CW'(DEPTH));
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees the slot the full-FIFO write lands in.
    assign push_ok   = push && (!out_full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            out_overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)      count <= count + CW'(1);
            else if (!push_ok && pop) count <= count - CW'(1);
            if (push && !push_ok) out_overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/io_port.sv
// CPU bus I/O stage: output FIFO on loadOut, synchronized strobed input latch on oeIN.
module io_port
    import io_port_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int SYNC_STAGES = SYNC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             loadOut,
    input  logic             oeIN,
    inout  wire  [WIDTH-1:0] bus,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_full,
    output logic             out_overflow,
    input  logic [WIDTH-1:0] in_pins,
    input  logic             in_strobe,
    output logic             in_pending
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] pins_pipe;
    logic [SYNC_STAGES-1:0]            strobe_pipe;
    logic                              strobe_prev;
    logic                              rise;
    logic [WIDTH-1:0]                  in_latch;

    assign bus  = oeIN ? in_latch : {WIDTH{1'bz}};
    assign rise = strobe_pipe[SYNC_STAGES-1] & ~strobe_prev;

    nibble_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (loadOut),
        .push_data   (bus),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_full    (out_full),
        .out_overflow(out_overflow)
    );

    // Index 0 takes the raw pin; the last stage is the synchronized value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pins_pipe   <= '0;
            strobe_pipe <= '0;
            strobe_prev <= 1'b0;
        end else begin
            pins_pipe   <= {pins_pipe[SYNC_STAGES-2:0], in_pins};
            strobe_pipe <= {strobe_pipe[SYNC_STAGES-2:0], in_strobe};
            strobe_prev <= strobe_pipe[SYNC_STAGES-1];
        end
    end

    // Capture takes priority over a read landing on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_latch   <= '0;
            in_pending <= 1'b0;
        end else if (rise) begin
            in_latch   <= pins_pipe[SYNC_STAGES-1];
            in_pending <= 1'b1;
        end else if (oeIN) begin
            in_pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_io_port.sv
// Directed self-checking bench for io_port.
module tb_io_port;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       loadOut = 1'b0;
    logic       oeIN = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_strobe = 1'b0;
    logic [3:0] in_pins = 4'h0;
    logic       tb_drv = 1'b0;
    logic [3:0] tb_bus = 4'h0;
    wire  [3:0] bus;
    logic [3:0] out_data;
    logic       out_valid, out_full, out_overflow, in_pending;

    int errors = 0;
    int checks = 0;

    assign bus = tb_drv ? tb_bus : 4'bzzzz;

    io_port dut (
        .clk         (clk),
        .reset       (reset),
        .loadOut     (loadOut),
        .oeIN        (oeIN),
        .bus         (bus),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_full    (out_full),
        .out_overflow(out_overflow),
        .in_pins     (in_pins),
        .in_strobe   (in_strobe),
        .in_pending  (in_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input logic [3:0] v);
        tb_drv = 1'b1; tb_bus = v; loadOut = 1'b1;
        step();
        loadOut = 1'b0; tb_drv = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid); end
        checks++; if (in_pending !== 1'b0) begin errors++; $display("FAIL rst_pending got %b exp 0", in_pending); end
        checks++; if (out_full !== 1'b0 || out_overflow !== 1'b0) begin errors++; $display("FAIL rst_flags got %b%b exp 00", out_full, out_overflow); end
        tb_drv = 1'b1; tb_bus = 4'h5; #1;
        checks++; if (bus !== 4'h5) begin errors++; $display("FAIL rst_bus_release got %h exp 5", bus); end
        tb_drv = 1'b0; oeIN = 1'b1; #1;
        checks++; if (bus !== 4'h0) begin errors++; $display("FAIL rst_latch got %h exp 0", bus); end
        oeIN = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        out_ready = 1'b0;
        push(4'hA);
        checks++; if (out_valid !== 1'b1 || out_data !== 4'hA) begin errors++; $display("FAIL basic_first got v=%b d=%h exp v=1 d=a", out_valid, out_data); end
        push(4'h3);
        checks++; if (out_data !== 4'hA) begin errors++; $display("FAIL basic_head got %h exp a", out_data); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 4'h3) begin errors++; $display("FAIL basic_pop1 got v=%b d=%h exp v=1 d=3", out_valid, out_data); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_empty got %b exp 0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b0 || out_full !== 1'b0) begin errors++; $display("FAIL basic_empty_ready got v=%b f=%b exp 0 0", out_valid, out_full); end
        out_ready = 1'b0;
    endtask

    task automatic test_full();
        logic [3:0] exp_d [4];
        exp_d = '{4'h1, 4'h2, 4'h3, 4'h4};
        for (int i = 0; i < 4; i++) push(exp_d[i]);
        checks++; if (out_full !== 1'b1 || out_data !== 4'h1) begin errors++; $display("FAIL full_set got f=%b d=%h exp f=1 d=1", out_full, out_data); end
        checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL full_noovf got %b exp 0", out_overflow); end
        push(4'h5);
        checks++; if (out_overflow !== 1'b1 || out_full !== 1'b1) begin errors++; $display("FAIL full_drop got o=%b f=%b exp 1 1", out_overflow, out_full); end
        step();
        checks++; if (out_overflow !== 1'b1) begin errors++; $display("FAIL full_sticky got %b exp 1", out_overflow); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== exp_d[i]) begin errors++; $display("FAIL full_drain%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, exp_d[i]); end
            step();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_full !== 1'b0 || out_overflow !== 1'b1) begin errors++; $display("FAIL full_after got v=%b f=%b o=%b exp 0 0 1", out_valid, out_full, out_overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [3:0] exp_d [4];
        exp_d = '{4'h2, 4'h3, 4'h4, 4'h9};
        for (int i = 1; i <= 4; i++) push(4'(i));
        out_ready = 1'b1;
        push(4'h9);
        checks++; if (out_full !== 1'b1 || out_data !== 4'h2) begin errors++; $display("FAIL fpp_count got f=%b d=%h exp f=1 d=2", out_full, out_data); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== exp_d[i]) begin errors++; $display("FAIL fpp_drain%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, exp_d[i]); end
            step();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_input();
        in_pins = 4'h6; in_strobe = 1'b1;
        step();
        checks++; if (in_pending !== 1'b0) begin errors++; $display("FAIL in_lat1 got %b exp 0", in_pending); end
        step();
        checks++; if (in_pending !== 1'b0) begin errors++; $display("FAIL in_lat2 got %b exp 0", in_pending); end
        in_strobe = 1'b0;
        step();
        checks++; if (in_pending !== 1'b1) begin errors++; $display("FAIL in_lat3 got %b exp 1", in_pending); end
        oeIN = 1'b1; #1;
        checks++; if (bus !== 4'h6) begin errors++; $display("FAIL in_bus got %h exp 6", bus); end
        step();
        oeIN = 1'b0;
        checks++; if (in_pending !== 1'b0) begin errors++; $display("FAIL in_read got %b exp 0", in_pending); end
        in_pins = 4'h7; in_strobe = 1'b1;
        step(); step(); step();
        checks++; if (in_pending !== 1'b1) begin errors++; $display("FAIL hold_cap got %b exp 1", in_pending); end
        oeIN = 1'b1;
        step();
        oeIN = 1'b0;
        for (int i = 0; i < 6; i++) step();
        checks++; if (in_pending !== 1'b0) begin errors++; $display("FAIL hold_once got %b exp 0", in_pending); end
        in_strobe = 1'b0;
        step(); step(); step();
    endtask

    task automatic test_coincident();
        in_pins = 4'h6; in_strobe = 1'b1;
        step(); step(); step();
        in_strobe = 1'b0;
        step(); step(); step();
        in_pins = 4'hC; in_strobe = 1'b1;
        step(); step();
        oeIN = 1'b1; #1;
        checks++; if (bus !== 4'h6) begin errors++; $display("FAIL coin_old got %h exp 6", bus); end
        step();
        checks++; if (in_pending !== 1'b1 || bus !== 4'hC) begin errors++; $display("FAIL coin_cap got p=%b bus=%h exp p=1 bus=c", in_pending, bus); end
        step();
        checks++; if (in_pending !== 1'b0) begin errors++; $display("FAIL coin_read got %b exp 0", in_pending); end
        loadOut = 1'b1;
        step();
        loadOut = 1'b0; oeIN = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 4'hC) begin errors++; $display("FAIL loopback got v=%b d=%h exp v=1 d=c", out_valid, out_data); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0; in_strobe = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL loop_drain got %b exp 0", out_valid); end
        step(); step(); step();
    endtask

    task automatic test_reset_mid();
        in_pins = 4'hB; in_strobe = 1'b1;
        push(4'h5); push(4'h6); push(4'h7);
        checks++; if (in_pending !== 1'b1 || out_data !== 4'h5) begin errors++; $display("FAIL mid_pre got p=%b d=%h exp p=1 d=5", in_pending, out_data); end
        out_ready = 1'b1;
        step();
        checks++; if (out_data !== 4'h6) begin errors++; $display("FAIL mid_pop got %h exp 6", out_data); end
        #2 reset = 1'b0; #1;
        checks++; if (out_valid !== 1'b0 || in_pending !== 1'b0) begin errors++; $display("FAIL mid_async got v=%b p=%b exp 0 0", out_valid, in_pending); end
        checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf got %b exp 0", out_overflow); end
        in_strobe = 1'b0; out_ready = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || in_pending !== 1'b0) begin errors++; $display("FAIL mid_post got v=%b p=%b exp 0 0", out_valid, in_pending); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] q[$];
        logic [9:0] rdy_pat;
        rdy_pat = 10'b1110110100;
        for (int i = 0; i < 10; i++) begin
            checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL wrap_valid%0d got %b exp %b", i, out_valid, q.size() != 0); end
            if (q.size() != 0) begin
                checks++; if (out_data !== q[0]) begin errors++; $display("FAIL wrap_data%0d got %h exp %h", i, out_data, q[0]); end
            end
            out_ready = rdy_pat[i];
            if (out_ready && q.size() != 0) void'(q.pop_front());
            if (q.size() < 4) q.push_back(4'(i + 3));
            push(4'(i + 3));
        end
        out_ready = 1'b1;
        while (q.size() != 0) begin
            checks++; if (out_valid !== 1'b1 || out_data !== q[0]) begin errors++; $display("FAIL wrap_drain got v=%b d=%h exp v=1 d=%h", out_valid, out_data, q[0]); end
            void'(q.pop_front());
            step();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_overflow !== 1'b0) begin errors++; $display("FAIL wrap_end got v=%b o=%b exp 0 0", out_valid, out_overflow); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_full_push_pop();
        test_input();
        test_coincident();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
